video_cfg_ctrl: RTL and testbench

VIDEO_CFG_CTRL -- requirements
Module: video_cfg_ctrl

---
 rtl/video_cfg_pkg.sv | 27 ++
 rtl/video_cfg_ctrl.sv | 140 ++++++++++++++
 tb/tb_video_cfg_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/video_cfg_pkg.sv
// Shared command codes, FSM state encoding and decode helper for the video config controller.
`default_nettype none

package video_cfg_pkg;

  localparam logic [7:0] CMD_OSD         = 8'h01;
  localparam logic [7:0] CMD_CFG_SCAN    = 8'h10;
  localparam logic [7:0] CMD_CFG_VOLUME  = 8'h11;
  localparam logic [7:0] CMD_CFG_WIDE    = 8'h12;
  localparam logic [7:0] CMD_CFG_VBREGEN = 8'h13;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_OSD     = 3'd2,
    ST_CFG     = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  // 0x10..0x13 share the upper six bits; the low two bits select the field.
  function automatic logic is_cfg_cmd(input logic [7:0] b);
    return (b[7:2] == CMD_CFG_SCAN[7:2]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_cfg_ctrl.sv
// MCU command decoder: forwards OSD byte streams and stages config values
// that are applied at the next vsync falling edge (volume ramps one step per frame).
`default_nettype none

module video_cfg_ctrl
  import video_cfg_pkg::*;
#(
  parameter logic [1:0] DEF_SCANLINES = 2'd0,
  parameter logic [1:0] DEF_VOLUME    = 2'd3,
  parameter logic       DEF_WIDE      = 1'b0,
  parameter logic       DEF_VBREGEN   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mcu_start,
  input  logic       mcu_strobe,
  input  logic [7:0] mcu_data,
  input  logic       vs_in_n,
  output logic       osd_start,
  output logic       osd_strobe,
  output logic [7:0] osd_data,
  output logic [1:0] system_scanlines,
  output logic [1:0] system_volume,
  output logic       system_wide_screen,
  output logic       vblank_regenerate,
  output logic       cfg_pending
);

  state_t     state, state_nxt;
  logic [1:0] cfg_idx, cfg_idx_nxt;
  logic       cmd_byte, start_nxt, strobe_nxt, cfg_wr;

  logic [1:0] scan_stg, scan_stg_nxt;
  logic [1:0] vol_tgt, vol_tgt_nxt;
  logic       wide_stg, wide_stg_nxt;
  logic       vbr_stg, vbr_stg_nxt;

  logic       vs_dly;
  logic       frame_edge;

  assign frame_edge = vs_dly & ~vs_in_n;

  always_comb begin
    state_nxt   = state;
    cfg_idx_nxt = cfg_idx;
    start_nxt   = 1'b0;
    strobe_nxt  = 1'b0;
    cfg_wr      = 1'b0;
    // A strobe coinciding with mcu_start is the command byte of the new transfer.
    cmd_byte    = mcu_strobe && (mcu_start || state == ST_CMD);

    if (mcu_start) state_nxt = ST_CMD;

    if (cmd_byte) begin
      if (mcu_data == CMD_OSD) begin
        state_nxt = ST_OSD;
        start_nxt = 1'b1;
      end else if (is_cfg_cmd(mcu_data)) begin
        state_nxt   = ST_CFG;
        cfg_idx_nxt = mcu_data[1:0];
      end else begin
        state_nxt = ST_DISCARD;
      end
    end else if (mcu_strobe && !mcu_start) begin
      case (state)
        ST_OSD: strobe_nxt = 1'b1;
        ST_CFG: begin
          cfg_wr    = 1'b1;
          state_nxt = ST_DISCARD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    scan_stg_nxt = scan_stg;
    vol_tgt_nxt  = vol_tgt;
    wide_stg_nxt = wide_stg;
    vbr_stg_nxt  = vbr_stg;
    if (cfg_wr) begin
      case (cfg_idx)
        2'd0:    scan_stg_nxt = mcu_data[1:0];
        2'd1:    vol_tgt_nxt  = mcu_data[1:0];
        2'd2:    wide_stg_nxt = mcu_data[0];
        default: vbr_stg_nxt  = mcu_data[0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cfg_idx    <= 2'd0;
      osd_start  <= 1'b0;
      osd_strobe <= 1'b0;
      osd_data   <= 8'h00;
    end else begin
      state      <= state_nxt;
      cfg_idx    <= cfg_idx_nxt;
      osd_start  <= start_nxt;
      osd_strobe <= strobe_nxt;
      if (strobe_nxt) osd_data <= mcu_data;
    end
  end

  // Applied values take the *next* staged value so a write on the edge cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_dly             <= 1'b1;
      scan_stg           <= DEF_SCANLINES;
      vol_tgt            <= DEF_VOLUME;
      wide_stg           <= DEF_WIDE;
      vbr_stg            <= DEF_VBREGEN;
      system_scanlines   <= DEF_SCANLINES;
      system_volume      <= 2'd0;
      system_wide_screen <= DEF_WIDE;
      vblank_regenerate  <= DEF_VBREGEN;
    end else begin
      vs_dly   <= vs_in_n;
      scan_stg <= scan_stg_nxt;
      vol_tgt  <= vol_tgt_nxt;
      wide_stg <= wide_stg_nxt;
      vbr_stg  <= vbr_stg_nxt;
      if (frame_edge) begin
        system_scanlines   <= scan_stg_nxt;
        system_wide_screen <= wide_stg_nxt;
        vblank_regenerate  <= vbr_stg_nxt;
        if (system_volume < vol_tgt_nxt)      system_volume <= system_volume + 2'd1;
        else if (system_volume > vol_tgt_nxt) system_volume <= system_volume - 2'd1;
      end
    end
  end

  assign cfg_pending = (scan_stg != system_scanlines) || (vol_tgt != system_volume) ||
                       (wide_stg != system_wide_screen) || (vbr_stg != vblank_regenerate);

endmodule

`default_nettype wire

// File: tb/tb_video_cfg_ctrl.sv
// Directed bench: OSD outputs go through a queue-based scoreboard; config outputs are checked against hand-computed values.
`timescale 1ns/1ps
`default_nettype none

module tb_video_cfg_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mcu_start = 1'b0;
  logic       mcu_strobe = 1'b0;
  logic [7:0] mcu_data = 8'h00;
  logic       vs_in_n = 1'b1;
  logic       osd_start, osd_strobe;
  logic [7:0] osd_data;
  logic [1:0] system_scanlines, system_volume;
  logic       system_wide_screen, vblank_regenerate, cfg_pending;

  video_cfg_ctrl #(
    .DEF_SCANLINES(2'd0), .DEF_VOLUME(2'd3), .DEF_WIDE(1'b0), .DEF_VBREGEN(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .mcu_start(mcu_start), .mcu_strobe(mcu_strobe), .mcu_data(mcu_data),
    .vs_in_n(vs_in_n),
    .osd_start(osd_start), .osd_strobe(osd_strobe), .osd_data(osd_data),
    .system_scanlines(system_scanlines), .system_volume(system_volume),
    .system_wide_screen(system_wide_screen), .vblank_regenerate(vblank_regenerate),
    .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_start;
    logic [7:0] data;
    int         cycle;
  } osd_exp_t;

  osd_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every OSD output event must match the head of the queue.
  always @(negedge clk) begin
    if (osd_start || osd_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL osd_unexpected: start=%0b strobe=%0b data=%0h expected no OSD activity",
                 osd_start, osd_strobe, osd_data);
      end else begin
        osd_exp_t e;
        e = exp_q.pop_front();
        if (osd_start !== e.is_start || osd_strobe !== !e.is_start ||
            (!e.is_start && osd_data !== e.data) || cyc != e.cycle) begin
          errors++;
          $display("FAIL osd_event: got start=%0b strobe=%0b data=%0h cyc=%0d expected start=%0b data=%0h cyc=%0d",
                   osd_start, osd_strobe, osd_data, cyc, e.is_start, e.data, e.cycle);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic st, input logic sb, input logic [7:0] d);
    mcu_start = st; mcu_strobe = sb; mcu_data = d;
    tick();
    mcu_start = 1'b0; mcu_strobe = 1'b0; mcu_data = 8'h00;
  endtask

  task automatic expect_osd(input bit is_start, input logic [7:0] d);
    osd_exp_t e;
    e.is_start = is_start; e.data = d; e.cycle = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic frame();
    vs_in_n = 1'b0;
    tick();
    vs_in_n = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_scan", {6'd0, system_scanlines}, 8'd0);
    chk("rst_vol", {6'd0, system_volume}, 8'd0);
    chk("rst_wide", {7'd0, system_wide_screen}, 8'd0);
    chk("rst_vbr", {7'd0, vblank_regenerate}, 8'd0);
    chk("rst_pending", {7'd0, cfg_pending}, 8'd1);
    chk("rst_osd", {6'd0, osd_start, osd_strobe}, 8'd0);
    chk("rst_osd_data", osd_data, 8'h00);

    // Soft-start ramp: 1, 2, 3, 3 with pending clearing after the third edge.
    for (int i = 1; i <= 4; i++) begin
      frame();
      chk($sformatf("ramp_vol%0d", i), {6'd0, system_volume}, (i > 3) ? 8'd3 : 8'(i));
      chk($sformatf("ramp_pend%0d", i), {7'd0, cfg_pending}, (i >= 3) ? 8'd0 : 8'd1);
    end

    // OSD stream.
    send(1'b1, 1'b0, 8'h00);
    expect_osd(1'b1, 8'h00); send(1'b0, 1'b1, 8'h01);
    tick();
    expect_osd(1'b0, 8'hAA); send(1'b0, 1'b1, 8'hAA);
    expect_osd(1'b0, 8'h55); send(1'b0, 1'b1, 8'h55);
    tick(); tick();
    chk("osd_drained", 8'(exp_q.size()), 8'd0);

    // Scanlines staged mid-frame, applied at next edge.
    send(1'b1, 1'b0, 8'h00);
    send(1'b0, 1'b1, 8'h10);
    send(1'b0, 1'b1, 8'h02);
    tick();
    chk("scan_hold", {6'd0, system_scanlines}, 8'd0);
    chk("scan_pend", {7'd0, cfg_pending}, 8'd1);
    frame();
    chk("scan_apply", {6'd0, system_scanlines}, 8'd2);
    chk("scan_pend_clr", {7'd0, cfg_pending}, 8'd0);

    // Unknown command discards the rest of the transfer.
    send(1'b1, 1'b0, 8'h00);
    send(1'b0, 1'b1, 8'h7F);
    send(1'b0, 1'b1, 8'h01);
    send(1'b0, 1'b1, 8'h33);
    frame();
    chk("disc_scan", {6'd0, system_scanlines}, 8'd2);
    chk("disc_vol", {6'd0, system_volume}, 8'd3);
    chk("disc_wide", {7'd0, system_wide_screen}, 8'd0);
    chk("disc_pend", {7'd0, cfg_pending}, 8'd0);

    // Wide write on the same cycle as the vsync edge.
    send(1'b1, 1'b0, 8'h00);
    send(1'b0, 1'b1, 8'h12);
    vs_in_n = 1'b0;
    send(1'b0, 1'b1, 8'h01);
    vs_in_n = 1'b1;
    chk("wide_edge", {7'd0, system_wide_screen}, 8'd1);
    chk("wide_pend", {7'd0, cfg_pending}, 8'd0);

    // Command byte on the start cycle; vbregen set.
    send(1'b1, 1'b1, 8'h13);
    send(1'b0, 1'b1, 8'h01);
    chk("vbr_pend", {7'd0, cfg_pending}, 8'd1);
    frame();
    chk("vbr_apply", {7'd0, vblank_regenerate}, 8'd1);

    // Volume ramps down to 0 and does not wrap.
    send(1'b1, 1'b1, 8'h11);
    send(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      frame();
      chk($sformatf("down_vol%0d", i), {6'd0, system_volume}, (i >= 3) ? 8'd0 : 8'(3 - i));
    end

    // Reset between OSD bytes aborts the stream.
    send(1'b1, 1'b0, 8'h00);
    expect_osd(1'b1, 8'h00); send(1'b0, 1'b1, 8'h01);
    expect_osd(1'b0, 8'hAA); send(1'b0, 1'b1, 8'hAA);
    do_reset();
    send(1'b0, 1'b1, 8'h11);
    send(1'b0, 1'b1, 8'h22);
    tick(); tick();
    chk("abort_drained", 8'(exp_q.size()), 8'd0);
    chk("abort_wide", {7'd0, system_wide_screen}, 8'd0);
    chk("abort_vol", {6'd0, system_volume}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
